// File: rtl/adder_scheduler_if.sv
// Request/response bundle for adder_scheduler.
// The req_chain wire is present only when ADDER_SCHED_CHAIN_EN is defined.
interface adder_scheduler_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_signed;
`ifdef ADDER_SCHED_CHAIN_EN
  logic [NREQ-1:0]       req_chain;
`endif
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;

  // Requesters and the result consumer
  modport master (
    output req_valid, req_a, req_b, req_cin, req_signed,
`ifdef ADDER_SCHED_CHAIN_EN
    output req_chain,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  // The scheduler itself
  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_signed,
`ifdef ADDER_SCHED_CHAIN_EN
    input  req_chain,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter in front of one shared WIDTH-bit adder.
// Flow is IDLE (grant) -> EXEC (add, register result) -> RESP (hold until taken).
// Optional build macro ADDER_SCHED_CHAIN_EN adds per-requester carry chaining
// for multi-word additions (carry saved at each response handshake).
module adder_scheduler #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_scheduler_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_signed;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic [IDW:0]     w_pos;
  logic [NREQ-1:0]  w_ready;
  logic             w_accept;
  logic             w_cin_sel;
  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH:0]   w_ext_b;
  logic [WIDTH:0]   w_total;
  logic             w_rsp_hs;

`ifdef ADDER_SCHED_CHAIN_EN
  logic [NREQ-1:0]  r_carry;
`endif

  // Round-robin search starting at r_ptr, wrapping past NREQ-1 back to 0
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_pos >= (IDW+1)'(NREQ)) begin
        w_pos = w_pos - (IDW+1)'(NREQ);
      end else begin
        w_pos = w_pos;
      end
      if (!w_found && bus.req_valid[w_pos[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_pos[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot ready to the winner, only while idle and out of reset
  always_comb begin
    w_ready = '0;
    if ((r_state == ST_IDLE) && w_found && rst_n) begin
      w_ready[w_grant] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  assign w_accept = |(bus.req_valid & w_ready);
  assign w_rsp_hs = (r_state == ST_RESP) && r_rsp_valid && bus.rsp_ready;

  // Carry-in selection: chained requesters take their saved carry instead of req_cin
  always_comb begin
`ifdef ADDER_SCHED_CHAIN_EN
    if (bus.req_chain[w_grant]) begin
      w_cin_sel = r_carry[w_grant];
    end else begin
      w_cin_sel = bus.req_cin[w_grant];
    end
`else
    w_cin_sel = bus.req_cin[w_grant];
`endif
  end

  // The single shared adder: operands extended by one bit (sign or zero) so the
  // top bit of the WIDTH+1 result is the carry-out in both modes
  always_comb begin
    w_ext_a = {r_signed & r_a[WIDTH-1], r_a};
    w_ext_b = {r_signed & r_b[WIDTH-1], r_b};
    w_total = w_ext_a + w_ext_b + {{WIDTH{1'b0}}, r_cin};
  end

  // Control FSM, operand capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_signed    <= 1'b0;
      r_id        <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= bus.req_a[w_grant*WIDTH +: WIDTH];
            r_b      <= bus.req_b[w_grant*WIDTH +: WIDTH];
            r_cin    <= w_cin_sel;
            r_signed <= bus.req_signed[w_grant];
            r_id     <= w_grant;
            r_ptr    <= (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + IDW'(1);
            r_busy   <= 1'b1;
            r_state  <= ST_EXEC;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_sum       <= w_total[WIDTH-1:0];
          r_cout      <= w_total[WIDTH];
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ADDER_SCHED_CHAIN_EN
  // Save the carry-out of each delivered result for that requester's next chained add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= '0;
    end else if (w_rsp_hs) begin
      r_carry[r_id] <= r_cout;
    end else begin
      r_carry <= r_carry;
    end
  end
`endif

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_cout  = r_cout;
  assign bus.busy      = r_busy;

endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 Parameter WIDTH, default 64, operand/sum width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..16); IDW = $clog2(NREQ).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ  per-requester operation request.
REQ-006 Port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port req_a  input  NREQ*WIDTH  operand A; requester i on bits [i*WIDTH +: WIDTH].
REQ-008 Port req_b  input  NREQ*WIDTH  operand B, same packing.
REQ-009 Port req_cin  input  NREQ  per-requester carry-in.
REQ-010 Port req_signed  input  NREQ  per-requester signed mode.
REQ-011 Port rsp_valid  output  1  result available.
REQ-012 Port rsp_ready  input  1  consumer accepts result.
REQ-013 Port rsp_id  output  IDW  index of requester owning the result.
REQ-014 Port rsp_sum  output  WIDTH  result sum.
REQ-015 Port rsp_cout  output  1  result carry-out.
REQ-016 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one shared add datapath instance, no other adder.
REQ-018 IDLE: if any req_valid, req_ready SHALL be driven combinationally high for the winner only; otherwise all req_ready low and state held.
REQ-019 Arbitration round-robin: search starts at priority pointer ptr, wraps from NREQ-1 to 0; first req_valid bit found wins.
REQ-020 On acceptance (req_valid[g] & req_ready[g]): capture a, b, cin, signed, id=g into operand registers; ptr <= (g+1) mod NREQ; go to EXEC.
REQ-021 EXEC (one cycle): unsigned mode {cout,sum} = a+b+cin zero-extended to WIDTH+1 bits; signed mode {cout,sum} = sign-extended a + sign-extended b + cin to WIDTH+1 bits; result registered; go to RESP.
REQ-022 RESP: rsp_valid high; rsp_id, rsp_sum, rsp_cout stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-023 Latency: acceptance in cycle N gives rsp_valid in cycle N+2; with rsp_ready tied high, one operation per 3 cycles.
REQ-024 req_ready SHALL be low in EXEC and RESP; req_valid may deassert at any time without protocol error.
REQ-025 rsp_valid, rsp_id, rsp_sum, rsp_cout SHALL NOT change in RESP while rsp_ready is low.
REQ-026 Operand changes on req_* after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, busy 0.
REQ-028 Reset mid-operation SHALL discard the in-flight operation with no response issued.
REQ-029 After rst_n rises, first grant SHALL search from requester 0.

Configuration
REQ-030 Macro ADDER_SCHED_CHAIN_EN compiles in multi-word carry chaining.
REQ-031 With macro: extra port req_chain  input  NREQ; per-requester carry register carry_q[NREQ], reset to 0.
REQ-032 With macro: if req_chain[g]=1 at acceptance, captured cin = carry_q[g] and req_cin[g] is ignored; else req_cin[g] is used.
REQ-033 With macro: carry_q[rsp_id] <= rsp_cout on response handshake; other entries unchanged.
REQ-034 Without macro: req_chain and carry_q absent; cin always req_cin[g].

Verification
REQ-035 Unsigned: req 0, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> 2 cycles later rsp_id=0, sum=0, cout=1.
REQ-036 Signed: req 2, a=-1, b=-1, cin=1, signed=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=1.
REQ-037 All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0, one accept every 3 cycles.
REQ-038 rsp_ready low 5 cycles in RESP -> rsp_* stable, all req_ready low, busy=1 throughout.
REQ-039 rst_n pulsed low during EXEC -> rsp_valid never asserts, busy=0 at once, next grant searches from 0.
REQ-040 ADDER_SCHED_CHAIN_EN: req 1 adds a=0xFFFF_FFFF_FFFF_FFFF, b=1 (cout=1), then chain add a=0, b=0 -> sum=1, cout=0.
